seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised multiplexed 7-segment driver for an N-digit common-anode display (Basys3: N=4).
//  Adds the following to plain cyclic digit scanning:
//  - frame-coherent input snapshot (no tearing)
//  - per-digit decimal-point mask
//  - leading-zero suppression
//  - per-digit blink
//  - PWM brightness
//  - one-cycle anti-ghost anode guard at every digit switch
//  Sits between timer/counter datapath (BCD nibbles) and board pins.
// PARAMETERS
//  NUM_DIGITS   4        digits scanned (>=2); index width = $clog2(NUM_DIGITS)
//  SCAN_DIV     262144   clk cycles per digit slot (>=4); 100MHz/4 digits -> ~95Hz frame
//  PWM_W        4        brightness resolution (bits)
//  BLINK_DIV_W  5        blink phase toggles every 2^BLINK_DIV_W frames
// PORTS
//  clk          in   1             system clock, 100MHz
//  clr_n        in   1             async reset, active low
//  x            in   4*NUM_DIGITS  nibble i = x[4i+3:4i], digit 0 rightmost
//  dp_mask      in   NUM_DIGITS    1 = light dot of digit i
//  blank_lz     in   1             1 = suppress leading zeros
//  blink_en     in   NUM_DIGITS    1 = digit i blinks
//  brightness   in   PWM_W         on-time duty; all-ones = 100%
//  a_to_g       out  7             segments gfedcba, active low, registered
//  an           out  NUM_DIGITS    anodes, active low, registered
//  dp           out  1             dot, active low, registered
//  frame_start  out  1             1-cycle pulse when snapshot taken
// BEHAVIOUR
//  Reset (clr_n=0, async, immediate):
//  - an = all 1
//  - a_to_g = 7'b1111111
//  - dp = 1, frame_start = 0
//  - prescaler, idx, pwm_cnt, frame/blink counters, snapshot regs = 0
//  Prescaler: counts 0..SCAN_DIV-1.
//  - At terminal count: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
//  Snapshot: when idx wraps to 0, and on first terminal count after reset:
//  - latch x, dp_mask, blink_en, blank_lz into snap_*
//  - frame_start=1 in the same cycle
//  - decode uses snap_* only; brightness is used live
//  Guard: in the cycle after idx changes, an = all 1.
//  - Then an[idx]=0 subject to PWM; other anodes 1.
//  Latency: a_to_g/dp/an registered, 1 cycle after idx/snap change.
//  PWM: pwm_cnt free-running PWM_W-bit counter, +1 every clk.
//  - anode enabled iff brightness==all-ones || pwm_cnt < brightness
//  - brightness=0 -> display dark; segments still driven
//  Decode (gfedcba, active low), by nibble value:
//  - 0 -> 1000000
//  - 1 -> 1111001
//  - 2 -> 0100100
//  - 3 -> 0110000
//  - 4 -> 0011001
//  - 5 -> 0010010
//  - 6 -> 0000010
//  - 7 -> 1111000
//  - 8 -> 0000000
//  - 9 -> 0010000
//  - A -> 0111111 (dash)
//  - B -> 1111111 (blank)
//  - C -> 1110111 (underscore)
//  - D, E, F -> 0000000 (error, all lit)
//  LZ suppress: digit i>0 blanked (1111111) iff snap_blank_lz and snap nibbles i..N-1 all 0.
//  - digit 0 never suppressed; dp still follows snap_dp_mask
//  Blink: frame counter counts frame_starts; blink phase toggles every 2^BLINK_DIV_W frames.
//  - phase=1 and snap_blink_en[i]: a_to_g=1111111, dp=1 for digit i
//  dp = ~snap_dp_mask[idx] unless blinked off.
//  Inputs changing mid-frame have no effect until the next snapshot.
// TESTING (bench: NUM_DIGITS=4, SCAN_DIV=4, PWM_W=2, BLINK_DIV_W=1)
//  1. Reset mid-scan: clr_n=0 -> an=1111, a_to_g=1111111, dp=1 same cycle.
//     Release -> first frame_start after 4 clk.
//  2. Scan order: x=16'h1234, brightness=3 -> an 1110,1101,1011,0111 repeating, 4 clk/slot.
//     Each slot: 1 guard cycle an=1111, then segments 4,3,2,1.
//  3. Snapshot: change x to 16'h5678 while idx=2 -> rest of frame still shows 1234.
//     Next frame shows 5678 after frame_start.
//  4. LZ: x=16'h0070, blank_lz=1 -> digits 3,2 blank, digit1=1111000, digit0=1000000.
//     x=16'h0000 -> only digit 0 shows 0.
//  5. dp/blink: dp_mask=0100, blink_en=0001 -> dp=0 only in slot 2.
//     Digit 0 blank on alternate 2-frame periods.
//  6. PWM: brightness=1 -> an[idx]=0 only when pwm_cnt==0 (25%).
//     brightness=0 -> an stays 1111.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit common-anode 7-segment driver.
// Ports: clk, clr_n (async low reset); x (BCD nibbles, digit 0 rightmost),
//   dp_mask, blank_lz, blink_en (snapshotted once per frame), brightness
//   (PWM duty, used live); a_to_g/an/dp active-low registered pin outputs,
//   frame_start one-cycle pulse when a new input snapshot is taken.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 262144,
    parameter int PWM_W       = 4,
    parameter int BLINK_DIV_W = 5
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic [4*NUM_DIGITS-1:0] x,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic [PWM_W-1:0]        brightness,
    output logic [6:0]              a_to_g,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    started;
    logic                    tc;
    logic                    last;
    logic                    snap_ev;

    logic [4*NUM_DIGITS-1:0] snap_x;
    logic [NUM_DIGITS-1:0]   snap_dp_mask;
    logic [NUM_DIGITS-1:0]   snap_blink_en;
    logic                    snap_blank_lz;

    logic [BLINK_DIV_W:0]    blink_cnt;
    logic                    blink_phase;
    logic [PWM_W-1:0]        pwm_cnt;

    logic [NUM_DIGITS-1:0]   zero_up;
    logic [3:0]              nib;
    logic                    sel_dp;
    logic                    sel_blink;
    logic                    sel_zero;
    logic [6:0]              seg;
    logic                    lz_blank;
    logic                    blink_off;
    logic                    an_on;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    assign tc   = (presc == PW'(SCAN_DIV - 1));
    assign last = (idx == IW'(NUM_DIGITS - 1));

    // A new frame begins when the scan wraps to digit 0; the very first
    // terminal count after reset also snapshots so the display never
    // waits a whole frame showing the reset contents.
    assign snap_ev = tc && (last || !started);

    // Phase is the counter MSB, so it flips every 2^BLINK_DIV_W frames.
    assign blink_phase = blink_cnt[BLINK_DIV_W];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc   <= '0;
            idx     <= '0;
            started <= 1'b0;
        end else begin
            presc <= tc ? '0 : presc + 1'b1;
            if (tc) begin
                idx     <= last ? '0 : idx + 1'b1;
                started <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            snap_x        <= '0;
            snap_dp_mask  <= '0;
            snap_blink_en <= '0;
            snap_blank_lz <= 1'b0;
            blink_cnt     <= '0;
        end else if (snap_ev) begin
            snap_x        <= x;
            snap_dp_mask  <= dp_mask;
            snap_blink_en <= blink_en;
            snap_blank_lz <= blank_lz;
            blink_cnt     <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // zero_up[i]: nibble i and every nibble above it are zero.
    always_comb begin : lz_scan
        logic run;
        run     = 1'b1;
        zero_up = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run        = run & (snap_x[4*i +: 4] == 4'd0);
            zero_up[i] = run;
        end
    end

    always_comb begin
        nib       = 4'd0;
        sel_dp    = 1'b0;
        sel_blink = 1'b0;
        sel_zero  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = snap_x[4*i +: 4];
                sel_dp    = snap_dp_mask[i];
                sel_blink = snap_blink_en[i];
                sel_zero  = zero_up[i];
            end
        end
    end

    always_comb begin
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0111111;
            4'hB:    seg = 7'b1111111;
            4'hC:    seg = 7'b1110111;
            default: seg = 7'b0000000;
        endcase
    end

    assign lz_blank  = snap_blank_lz && (idx != '0) && sel_zero;
    assign blink_off = blink_phase && sel_blink;
    assign an_on     = (&brightness) || (pwm_cnt < brightness);

    // On the terminal count all anodes go dark for one cycle so the
    // segment change to the next digit never shows on the old anode.
    always_comb begin
        an_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt[i] = ~(an_on && !tc && (idx == IW'(i)));
        end
    end

    assign seg_nxt = (blink_off || lz_blank) ? 7'b1111111 : seg;
    assign dp_nxt  = blink_off ? 1'b1 : ~sel_dp;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_to_g      <= 7'b1111111;
            an          <= '1;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            a_to_g      <= seg_nxt;
            an          <= an_nxt;
            dp          <= dp_nxt;
            frame_start <= snap_ev;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver.
// Expected digit slots are queued at each frame_start and popped on lit slots.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] x;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [3:0]  blink_en;
    logic [1:0]  brightness;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .PWM_W      (2),
        .BLINK_DIV_W(1)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .x          (x),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .brightness (brightness),
        .a_to_g     (a_to_g),
        .an         (an),
        .dp         (dp),
        .frame_start(frame_start)
    );

    typedef struct {
        int         d;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_en = 0;
    int         fcnt = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    logic [3:0] an_prev = 4'hf;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0111111;
            4'hB: return 7'b1111111;
            4'hC: return 7'b1110111;
            default: return 7'b0000000;
        endcase
    endfunction

    always @(negedge clr_n) fcnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (clr_n && frame_start) fcnt++;
        if (mon_en && an !== 4'hf && an_prev === 4'hf) begin
            n_chk++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_slot got an=%b seg=%b dp=%b, want none",
                         an, a_to_g, dp);
            end else begin
                e = q.pop_front();
                if (an !== e.an || a_to_g !== e.seg || dp !== e.dp ||
                    (e.d != 0 && cyc - last_cyc != 4))
                    $display("FAIL slot%0d got an=%b seg=%b dp=%b gap=%0d, want an=%b seg=%b dp=%b gap=4",
                             e.d, an, a_to_g, dp, cyc - last_cyc, e.an, e.seg, e.dp);
                else
                    n_pass++;
                last_cyc = cyc;
            end
        end
        an_prev = an;
    end

    // Expected frame from the inputs as applied at the snapshot.
    task automatic push_frame();
        exp_t t;
        logic ph;
        logic allz;
        logic [3:0] nb;
        ph = fcnt[1];
        for (int d = 0; d < 4; d++) begin
            nb = x[4*d +: 4];
            allz = 1'b1;
            for (int j = d; j < 4; j++)
                if (x[4*j +: 4] != 4'd0) allz = 1'b0;
            t.d = d;
            t.an = 4'hf;
            t.an[d] = 1'b0;
            if (ph && blink_en[d]) begin
                t.seg = 7'h7f;
                t.dp = 1'b1;
            end else begin
                t.seg = (blank_lz && d != 0 && allz) ? 7'h7f : dec7(nb);
                t.dp = ~dp_mask[d];
            end
            q.push_back(t);
        end
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 64);
        #1;
        n_chk++;
        if (frame_start !== 1'b1)
            $display("FAIL frame_start_timeout got %b, want 1", frame_start);
        else
            n_pass++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 64) begin
            @(negedge clk);
            k++;
        end
        #1;
        n_chk++;
        if (q.size() != 0) begin
            $display("FAIL drain_timeout got %0d pending, want 0", q.size());
            q.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            wait_fs();
            push_frame();
            mon_en = 1;
            drain();
        end
        mon_en = 0;
    endtask

    task automatic test_reset();
        int k;
        clr_n = 1'b0;
        x = 16'h1234;
        dp_mask = 4'h0;
        blank_lz = 1'b0;
        blink_en = 4'h0;
        brightness = 2'd3;
        repeat (2) @(negedge clk);
        n_chk++;
        if (an !== 4'hf || a_to_g !== 7'h7f || dp !== 1'b1 || frame_start !== 1'b0)
            $display("FAIL reset_state got an=%b seg=%b dp=%b fs=%b, want 1111 1111111 1 0",
                     an, a_to_g, dp, frame_start);
        else
            n_pass++;
        clr_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 20);
        n_chk++;
        if (k != 4) $display("FAIL first_fs got %0d clk, want 4", k);
        else n_pass++;
        k = 0;
        while (an === 4'hf && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (an === 4'hf) $display("FAIL lit_before_reset got an=%b, want lit", an);
        else n_pass++;
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        n_chk++;
        if (an !== 4'hf || a_to_g !== 7'h7f || dp !== 1'b1 || frame_start !== 1'b0)
            $display("FAIL async_reset got an=%b seg=%b dp=%b fs=%b, want 1111 1111111 1 0",
                     an, a_to_g, dp, frame_start);
        else
            n_pass++;
        @(negedge clk);
        clr_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 20);
        n_chk++;
        if (k != 4) $display("FAIL fs_after_reset got %0d clk, want 4", k);
        else n_pass++;
    endtask

    task automatic test_scan();
        x = 16'h1234;
        brightness = 2'd3;
        run_frames(2);
    endtask

    task automatic test_snapshot();
        x = 16'h1234;
        wait_fs();
        push_frame();
        mon_en = 1;
        repeat (8) @(negedge clk);
        x = 16'h5678;
        drain();
        run_frames(1);
    endtask

    task automatic test_decode();
        x = 16'hABCD;
        run_frames(1);
        x = 16'hEF90;
        run_frames(1);
    endtask

    task automatic test_lz();
        blank_lz = 1'b1;
        x = 16'h0070;
        run_frames(1);
        x = 16'h0000;
        dp_mask = 4'b1000;
        run_frames(1);
        x = 16'h0102;
        dp_mask = 4'h0;
        run_frames(1);
        blank_lz = 1'b0;
    endtask

    task automatic test_dp_blink();
        x = 16'h1234;
        dp_mask = 4'b0100;
        blink_en = 4'b0001;
        run_frames(4);
        dp_mask = 4'h0;
        blink_en = 4'h0;
    endtask

    task automatic test_pwm();
        int cnt;
        int want;
        x = 16'h1234;
        brightness = 2'd1;
        run_frames(1);
        for (int b = 0; b < 4; b++) begin
            brightness = 2'(b);
            want = (b == 0) ? 0 : 8 * b;
            repeat (2) @(negedge clk);
            cnt = 0;
            repeat (32) begin
                @(negedge clk);
                if (an !== 4'hf) cnt++;
            end
            n_chk++;
            if (cnt != want)
                $display("FAIL pwm_b%0d got %0d lit, want %0d", b, cnt, want);
            else
                n_pass++;
        end
        brightness = 2'd3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_decode();
        test_lz();
        test_dp_blink();
        test_pwm();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
